// File: rtl/dc_mem_ctrl_pkg.sv
// Shared widths, stall-bus encoding and SRAM request payload for the DC-stage
// memory access controller.
package dc_mem_ctrl_pkg;

  localparam int unsigned STALL_W     = 6;
  localparam int unsigned STALL_IDX_W = $clog2(STALL_W);
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned WEN_W       = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef struct packed {
    logic [WEN_W-1:0]  wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

  // Any byte enable set marks the access as a store.
  function automatic logic is_store(input logic [WEN_W-1:0] wen);
    return |wen;
  endfunction

endpackage

// File: rtl/dc_mem_ctrl.sv
// DC-stage data-memory access controller: drives one load/store onto the
// split addr_ok/data_ok SRAM bus, stalls the pipeline while it is in flight.
module dc_mem_ctrl
  import dc_mem_ctrl_pkg::*;
#(
  parameter int unsigned STALL_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [STALL_W-1:0] stall,
  input  logic              data_ram_en,
  input  logic [WEN_W-1:0]  data_ram_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              data_sram_req,
  output logic [WEN_W-1:0]  data_sram_wen,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              stallreq_dc,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_CANCEL = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] dc_rdata_q, dc_rdata_d;
  logic              dc_done_q, dc_done_d;
  logic              req_c, stallreq_c;
  logic              dc_stop_c;
  sram_req_t         bus_c;
  logic              unused_stall;

  assign dc_stop_c    = (stall[STALL_IDX_W'(STALL_BIT)] == STOP);
  assign unused_stall = ^stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dc_rdata_q <= '0;
      dc_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dc_rdata_q <= dc_rdata_d;
      dc_done_q  <= dc_done_d;
    end
  end

  // Next state, handshake outputs and load-data capture.
  always_comb begin
    state_d    = state_q;
    dc_rdata_d = dc_rdata_q;
    req_c      = 1'b0;
    stallreq_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_ram_en && !flush) begin
          req_c      = 1'b1;
          stallreq_c = 1'b1;
          state_d    = data_sram_addr_ok ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        req_c      = 1'b1;
        stallreq_c = 1'b1;
        if (data_sram_addr_ok) begin
          state_d = flush ? S_CANCEL : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stallreq_c = 1'b1;
        if (data_sram_data_ok) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (!is_store(data_ram_wen)) begin
              dc_rdata_d = data_sram_rdata;
            end
          end
        end else if (flush) begin
          state_d = S_CANCEL;
        end
      end
      S_DONE: begin
        if (flush || !dc_stop_c) begin
          state_d = S_IDLE;
        end
      end
      S_CANCEL: begin
        // Hold any new access off the bus until the orphaned response drains.
        stallreq_c = data_ram_en;
        if (data_sram_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      dc_rdata_d = '0;
    end
    dc_done_d = (state_d == S_DONE);
  end

  // Bus payload is only presented while the request is up.
  always_comb begin
    bus_c = '0;
    if (req_c) begin
      bus_c.wen   = data_ram_wen;
      bus_c.addr  = mem_addr;
      bus_c.wdata = mem_wdata;
    end
  end

  assign data_sram_req   = req_c;
  assign data_sram_wen   = bus_c.wen;
  assign data_sram_addr  = bus_c.addr;
  assign data_sram_wdata = bus_c.wdata;
  assign stallreq_dc     = stallreq_c;
  assign dc_rdata        = dc_rdata_q;
  assign dc_done         = dc_done_q;

endmodule

// File: tb/tb_dc_mem_ctrl.sv
// Self-checking bench for dc_mem_ctrl: directed scenarios plus randomized
// transactions checked against a cycle-count model of each access.
module tb_dc_mem_ctrl;

  localparam int SB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        data_sram_req;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        stallreq_dc;
  logic [31:0] dc_rdata;
  logic        dc_done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  dc_mem_ctrl #(.STALL_BIT(SB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .data_ram_en(data_ram_en), .data_ram_wen(data_ram_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .data_sram_req(data_sram_req), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .stallreq_dc(stallreq_dc),
    .dc_rdata(dc_rdata), .dc_done(dc_done)
  );

  task automatic drive_quiet();
    rst = 1'b0; flush = 1'b0; stall = 6'($urandom);
    data_ram_en = 1'b0; data_ram_wen = '0; mem_addr = '0; mem_wdata = '0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
  endtask

  // Cycle-level check of the four control outputs against expected values.
  task automatic check_ctl(input string tag, input logic ereq, input logic estl,
                           input logic edone);
    checks++;
    if (data_sram_req !== ereq) begin
      errors++; $display("FAIL %s req got %b exp %b", tag, data_sram_req, ereq);
    end
    checks++;
    if (stallreq_dc !== estl) begin
      errors++; $display("FAIL %s stallreq got %b exp %b", tag, stallreq_dc, estl);
    end
    checks++;
    if (dc_done !== edone) begin
      errors++; $display("FAIL %s done got %b exp %b", tag, dc_done, edone);
    end
    checks++;
    if (dc_rdata !== exp_rdata) begin
      errors++; $display("FAIL %s rdata got %h exp %h", tag, dc_rdata, exp_rdata);
    end
  endtask

  // One access from IDLE: addr_ok at cycle a, data_ok d cycles later,
  // then h extra DONE cycles held by the pipeline stall bit.
  task automatic run_access(input string tag, input logic st, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] rd,
                            input int a, input int d, input int h);
    int          last;
    logic [31:0] wd;
    logic        ereq, estl, edone;
    last = a + d + 1 + h;
    wd   = $urandom;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      drive_quiet();
      data_ram_en       = 1'b1;
      data_ram_wen      = st ? wen : 4'b0000;
      mem_addr          = addr;
      mem_wdata         = wd;
      data_sram_addr_ok = (c == a);
      data_sram_data_ok = (c == a + d);
      data_sram_rdata   = (c == a + d) ? rd : 32'($urandom);
      if (c >= a + d + 1) stall[SB] = (c < last) ? 1'b1 : 1'b0;
      if (c == a + d + 1 && !st) exp_rdata = rd;
      #1;
      ereq  = (c <= a);
      estl  = (c <= a + d);
      edone = (c >= a + d + 1);
      check_ctl($sformatf("%s c%0d", tag, c), ereq, estl, edone);
      if (ereq) begin
        checks++;
        if (data_sram_addr !== addr || data_sram_wen !== data_ram_wen || data_sram_wdata !== wd) begin
          errors++;
          $display("FAIL %s c%0d bus got %h/%b/%h exp %h/%b/%h", tag, c, data_sram_addr,
                   data_sram_wen, data_sram_wdata, addr, data_ram_wen, wd);
        end
      end
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    drive_quiet();
    #1;
    check_ctl(tag, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive_quiet();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_rdata = '0;
    check_ctl("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycle("post_reset");
  endtask

  task automatic test_zero_wait_load();
    run_access("zw_load", 1'b0, 4'b0000, 32'h8000_0010, 32'hDEAD_BEEF, 0, 1, 0);
    idle_cycle("zw_idle");
  endtask

  task automatic test_store_delayed();
    run_access("st_delay", 1'b1, 4'b0011, 32'h8000_0020, 32'h1234_5678, 3, 2, 0);
    idle_cycle("st_idle");
  endtask

  task automatic test_stall_hold();
    run_access("hold", 1'b0, 4'b0000, 32'h8000_0030, 32'hCAFE_F00D, 0, 1, 3);
    idle_cycle("hold_idle");
  endtask

  task automatic test_flush_wait();
    // flush in WAIT without data_ok -> CANCEL, orphan data dropped
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; mem_addr = 32'h8000_0040; data_sram_addr_ok = 1'b1;
    #1; check_ctl("fw c0", 1'b1, 1'b1, 1'b0);
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; mem_addr = 32'h8000_0040; flush = 1'b1;
    #1; check_ctl("fw c1", 1'b0, 1'b1, 1'b0);
    exp_rdata = '0;
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; mem_addr = 32'h8000_0044;
    #1; check_ctl("fw c2", 1'b0, 1'b1, 1'b0);
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; mem_addr = 32'h8000_0044;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0_BAD0;
    #1; check_ctl("fw c3", 1'b0, 1'b1, 1'b0);
    run_access("fw_new", 1'b0, 4'b0000, 32'h8000_0044, 32'h0BAD_CAFE, 1, 2, 0);
    // flush coincident with data_ok in WAIT -> IDLE, data discarded
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; data_sram_addr_ok = 1'b1;
    #1; check_ctl("fwd c0", 1'b1, 1'b1, 1'b0);
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_AAAA;
    #1; check_ctl("fwd c1", 1'b0, 1'b1, 1'b0);
    exp_rdata = '0;
    idle_cycle("fwd c2");
  endtask

  task automatic test_flush_req();
    // flush in IDLE masks a new access
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; flush = 1'b1;
    #1; check_ctl("fi c0", 1'b0, 1'b0, 1'b0);
    exp_rdata = '0;
    // flush in REQ without addr_ok -> request withdrawn
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1;
    #1; check_ctl("fr c0", 1'b1, 1'b1, 1'b0);
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; flush = 1'b1;
    #1; check_ctl("fr c1", 1'b1, 1'b1, 1'b0);
    idle_cycle("fr c2");
    idle_cycle("fr c3");
    // flush coincident with addr_ok in REQ -> CANCEL until data_ok
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1;
    #1; check_ctl("fra c0", 1'b1, 1'b1, 1'b0);
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; flush = 1'b1; data_sram_addr_ok = 1'b1;
    #1; check_ctl("fra c1", 1'b1, 1'b1, 1'b0);
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1;
    #1; check_ctl("fra c2", 1'b0, 1'b1, 1'b0);
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFEED_0001;
    #1; check_ctl("fra c3", 1'b0, 1'b1, 1'b0);
    run_access("fra_new", 1'b0, 4'b0000, 32'h8000_0050, 32'h7777_0001, 0, 1, 0);
  endtask

  task automatic test_flush_done();
    run_access("fd", 1'b0, 4'b0000, 32'h8000_0060, 32'h2468_ACE0, 0, 1, 0);
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; data_sram_addr_ok = 1'b1;
    #1; check_ctl("fd2 c0", 1'b1, 1'b1, 1'b0);
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1357_9BDF;
    #1; check_ctl("fd2 c1", 1'b0, 1'b1, 1'b0);
    exp_rdata = 32'h1357_9BDF;
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; stall[SB] = 1'b1; flush = 1'b1;
    #1; check_ctl("fd2 c2", 1'b0, 1'b0, 1'b1);
    exp_rdata = '0;
    idle_cycle("fd2 c3");
  endtask

  task automatic test_rst_wait();
    run_access("rw_pre", 1'b0, 4'b0000, 32'h8000_0070, 32'hA5A5_5A5A, 0, 1, 0);
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; data_sram_addr_ok = 1'b1;
    #1; check_ctl("rw c0", 1'b1, 1'b1, 1'b0);
    @(negedge clk); drive_quiet();
    data_ram_en = 1'b1; rst = 1'b1;
    #1; check_ctl("rw c1", 1'b0, 1'b1, 1'b0);
    exp_rdata = '0;
    @(negedge clk); drive_quiet();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_0000;
    #1; check_ctl("rw c2", 1'b0, 1'b0, 1'b0);
    idle_cycle("rw c3");
    run_access("rw_new", 1'b1, 4'b1111, 32'h8000_0074, 32'h0, 1, 1, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic       st;
      logic [3:0] wen;
      st  = 1'($urandom_range(0, 1));
      wen = 4'($urandom_range(1, 15));
      run_access($sformatf("rnd%0d", i), st, wen, $urandom, $urandom,
                 $urandom_range(0, 4), $urandom_range(1, 4), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle_cycle($sformatf("rnd%0d_idle", i));
    end
  endtask

  initial begin
    drive_quiet();
    rst = 1'b1;
    test_reset();
    test_zero_wait_load();
    test_store_delayed();
    test_stall_hold();
    test_flush_wait();
    test_flush_req();
    test_flush_done();
    test_rst_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
